// File: rtl/mem_responder_pkg.sv
// Shared definitions for mem_responder: IO map, status bit positions and the
// access decoder used by the top level.
package mem_responder_pkg;

  localparam logic [1:0]  IO_SEL       = 2'b11;
  localparam logic [17:0] IO_TX_ADDR   = 18'h30000;
  localparam logic [17:0] IO_HALT_ADDR = 18'h30004;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_RAM_RD,
    ACC_RAM_WR,
    ACC_IO_RD,
    ACC_TX_WR,
    ACC_HALT_WR
  } acc_kind_e;

  // Classifies one controller cycle; undefined IO writes collapse to ACC_NONE.
  function automatic acc_kind_e decode_access(input logic en, input logic wr,
                                               input logic [17:0] a);
    if (!en) return ACC_NONE;
    if (a[17:16] != IO_SEL) return wr ? ACC_RAM_WR : ACC_RAM_RD;
    if (!wr) return ACC_IO_RD;
    if (a == IO_TX_ADDR) return ACC_TX_WR;
    if (a == IO_HALT_ADDR) return ACC_HALT_WR;
    return ACC_NONE;
  endfunction

endpackage

// File: rtl/mem_responder_byte_fifo.sv
// byte_fifo: power-of-two byte queue with combinational head, accepting a
// push while full when the same edge pops.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = mem[rd_ptr_q];

  // When full, wr_ptr == rd_ptr: the popped head is read before this edge
  // overwrites the same slot, so push+pop while full is safe.
  always_comb begin
    push_ok  = push && (!full || pop);
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop_ok) count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte RAM plus TX-byte IO window for a memory controller.
// Define MEM_RESPONDER_HALT_EN to enable the halt register at 0x30004.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [31:0]       mem_a,
  input  logic              mem_wr,
  input  logic [7:0]        mem_dout,
  output logic [7:0]        mem_din,
  output logic              io_full,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  input  logic              init_we,
  input  logic [RAM_AW-1:0] init_addr,
  input  logic [7:0]        init_data,
  output logic              halt,
  output logic              tx_ovf
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [7:0]        ram [2**RAM_AW];
  acc_kind_e         acc;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_wa;
  logic [7:0]        ram_wd;
  logic [7:0]        mem_din_q, mem_din_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CW-1:0]     fifo_count;
  logic [7:0]        status;
  logic              unused_mem_a_hi;

  assign unused_mem_a_hi = ^mem_a[31:18];

  always_comb acc = decode_access(rdy, mem_wr, mem_a[17:0]);

  // Preload port wins the single RAM write port and ignores rdy.
  always_comb begin
    ram_we = init_we || (acc == ACC_RAM_WR);
    ram_wa = init_we ? init_addr : mem_a[RAM_AW-1:0];
    ram_wd = init_we ? init_data : mem_dout;
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
  end

  always_comb begin
    status                 = '0;
    status[STAT_EMPTY_BIT] = fifo_empty;
    status[STAT_FULL_BIT]  = fifo_full;
  end

  always_comb begin
    mem_din_d = mem_din_q;
    case (acc)
      ACC_RAM_RD: mem_din_d = ram[mem_a[RAM_AW-1:0]];
      ACC_IO_RD:  mem_din_d = status;
      default:    mem_din_d = mem_din_q;
    endcase
  end

  always_comb begin
    fifo_push = (acc == ACC_TX_WR);
    fifo_pop  = tx_valid && tx_ready;
    tx_ovf_d  = tx_ovf_q || (fifo_push && fifo_full && !fifo_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_din_q <= '0;
      tx_ovf_q  <= 1'b0;
    end else begin
      mem_din_q <= mem_din_d;
      tx_ovf_q  <= tx_ovf_d;
    end
  end

  byte_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (mem_dout),
    .pop   (fifo_pop),
    .dout  (tx_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

`ifdef MEM_RESPONDER_HALT_EN
  logic halt_q, halt_d;

  always_comb halt_d = halt_q || (acc == ACC_HALT_WR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) halt_q <= 1'b0;
    else      halt_q <= halt_d;
  end

  assign halt = halt_q;
`else
  assign halt = 1'b0;
`endif

  assign mem_din  = mem_din_q;
  assign tx_ovf   = tx_ovf_q;
  assign tx_valid = !fifo_empty;
  assign io_full  = (fifo_count >= CW'(TX_DEPTH - 2));

endmodule
